// File: rtl/uart_rx_fifo_pkg.sv
// Shared widths, depth and capture-FSM encoding for the UART receive FIFO.
package UART_MIKE_pkg;

  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_RX_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PUSH  = 2'd1,
    CLEAR = 2'd2
  } rx_fifo_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; head entry is read
// combinationally and forced to zero while empty.
module uart_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop && !full)       count_d = count_q + 1'b1;
    else if (do_pop && !do_push && !empty) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures bytes from the UART core with a flag/clear handshake and queues
// them, each tagged with its parity status, for a ready/valid consumer.
module uart_rx_fifo
  import UART_MIKE_pkg::*;
#(
  parameter int DATA_W = UART_DATA_WIDTH,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   rx_flag,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   parity_error,
  output logic                   rx_flag_clr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_perr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  rx_fifo_state_e    state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rx_flag_clr_q, rx_flag_clr_d;
  logic              overflow_q, overflow_d;
  logic              ovf_set;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W:0]   fifo_rd;

  assign fifo_pop = rd_valid & rd_ready;

  // The keep/drop decision is made in PUSH; the write itself lands one edge
  // later, so an accepted byte shows up two edges after rx_flag is sampled.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    perr_d    = perr_q;
    wr_pend_d = 1'b0;
    ovf_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_flag) begin
          state_d = PUSH;
          data_d  = rx_data;
          perr_d  = parity_error;
        end
      end
      PUSH: begin
        state_d = CLEAR;
        if (fifo_full && !fifo_pop) ovf_set   = 1'b1;
        else                        wr_pend_d = 1'b1;
      end
      CLEAR: begin
        if (!rx_flag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rx_flag_clr_d = (state_d == CLEAR);
    overflow_d    = ovf_set | (overflow_q & ~overflow_clr);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      perr_q        <= 1'b0;
      wr_pend_q     <= 1'b0;
      rx_flag_clr_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      perr_q        <= perr_d;
      wr_pend_q     <= wr_pend_d;
      rx_flag_clr_q <= rx_flag_clr_d;
      overflow_q    <= overflow_d;
    end
  end

  uart_sync_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (wr_pend_q),
    .wr_data ({perr_q, data_q}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rd_valid    = ~fifo_empty;
  assign rd_data     = fifo_rd[DATA_W-1:0];
  assign rd_perr     = fifo_rd[DATA_W];
  assign rx_flag_clr = rx_flag_clr_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic                   clk = 1'b0;
  logic                   n_rst, rx_flag, parity_error, rd_ready, overflow_clr;
  logic [DW-1:0]          rx_data, rd_data;
  logic                   rx_flag_clr, rd_perr, rd_valid, overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pops = 0;
  logic [DW:0] mq[$];
  bit          ovf_m = 1'b0;
  bit          mon_le1 = 1'b0;

  uart_rx_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_flag      (rx_flag),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .rx_flag_clr  (rx_flag_clr),
    .rd_data      (rd_data),
    .rd_perr      (rd_perr),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cmp_state();
    logic [DW:0] hd;
    hd = (mq.size() != 0) ? mq[0] : '0;
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("valid", 32'(rd_valid), 32'(mq.size() != 0));
    chk("data",  32'(rd_data), 32'(hd[DW-1:0]));
    chk("perr",  32'(rd_perr), 32'(hd[DW]));
    chk("ovf",   32'(overflow), 32'(ovf_m));
    if (mon_le1) chk("cnt_le1", 32'(fifo_count <= 1), 32'd1);
  endtask

  // Advance one clock; apply the consumer-side effects of that edge to the model.
  task automatic tick();
    bit do_pop, do_clr;
    do_pop = rd_ready && (mq.size() != 0);
    do_clr = overflow_clr;
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(mq.pop_front());
      n_pops++;
    end
    if (do_clr) ovf_m = 1'b0;
  endtask

  task automatic step();
    tick();
    cmp_state();
  endtask

  task automatic pop1();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  // Present one byte held for h cycles; pip pulses rd_ready during the PUSH cycle.
  task automatic send_byte(input logic [DW-1:0] d, input bit p, input int h, input bit pip);
    bit drop;
    int c;
    int g;
    drop = 1'b0;
    c = 0;
    rx_data = d;
    parity_error = p;
    rx_flag = 1'b1;
    while (c < 3 || c < h) begin
      if (c == 1) begin
        if (pip) rd_ready = 1'b1;
        drop = (mq.size() == DEPTH) && !(rd_ready && mq.size() != 0);
      end
      tick();
      c++;
      if (pip && c == 2) rd_ready = 1'b0;
      if (c == h) begin
        rx_flag = 1'b0;
        rx_data = DW'($urandom);
        parity_error = 1'($urandom);
      end
      if (c == 2 && drop) ovf_m = 1'b1;
      if (c == 3 && !drop) mq.push_back({p, d});
      if (c == 1) chk("clr_lo", 32'(rx_flag_clr), 32'd0);
      if (c == 2) chk("clr_hi", 32'(rx_flag_clr), 32'd1);
      if (c > 2 && c <= h) chk("clr_hold", 32'(rx_flag_clr), 32'd1);
      cmp_state();
    end
    g = 0;
    while (rx_flag_clr && g < 4) begin
      step();
      g++;
    end
    chk("clr_fall", 32'(rx_flag_clr), 32'd0);
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) send_byte(base + DW'(i), 1'(i & 1), 1 + (i % 3), 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    n_rst = 1'b1; rx_flag = 1'b0; rx_data = '0; parity_error = 1'b0;
    rd_ready = 1'b0; overflow_clr = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    cmp_state();
    chk("rst_clr", 32'(rx_flag_clr), 32'd0);
    repeat (2) step();
    n_rst = 1'b1;
    step();

    // single byte held six cycles
    send_byte(8'h55, 1'b0, 6, 1'b0);
    chk("single_cnt",  32'(fifo_count), 32'd1);
    chk("single_data", 32'(rd_data), 32'h55);
    chk("single_perr", 32'(rd_perr), 32'd0);
    pop1();

    // parity tag kept with the byte
    send_byte(8'hA5, 1'b1, 2, 1'b0);
    chk("perr_tag", 32'(rd_perr), 32'd1);
    chk("perr_data", 32'(rd_data), 32'hA5);
    pop1();
    chk("pop_valid", 32'(rd_valid), 32'd0);
    chk("pop_data",  32'(rd_data), 32'd0);

    // fill, overflow, ordered drain, overflow clear
    for (int i = 0; i < 9; i++) send_byte(DW'(i), 1'b0, 1 + (i % 3), 1'b0);
    chk("full_cnt", 32'(fifo_count), 32'd8);
    chk("full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("drain", 32'(rd_data), 32'(i));
      pop1();
    end
    chk("drain_empty", 32'(rd_valid), 32'd0);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // full with a pop in the PUSH cycle
    fill(8, 8'h10);
    chk("pip_head", 32'(rd_data), 32'h10);
    send_byte(8'h99, 1'b1, 2, 1'b1);
    chk("pip_ovf", 32'(overflow), 32'd0);
    chk("pip_cnt", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 7; i++) begin
      chk("pip_order", 32'(rd_data), 32'h11 + 32'(i));
      pop1();
    end
    chk("late_head", 32'(rd_data), 32'h99);
    chk("late_perr", 32'(rd_perr), 32'd1);
    pop1();

    // pointer wrap with continuous consumer
    p0 = n_pops;
    mon_le1 = 1'b1;
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send_byte(DW'($urandom), 1'($urandom), int'($urandom_range(1, 3)), 1'b0);
    step();
    mon_le1 = 1'b0;
    rd_ready = 1'b0;
    chk("wrap_pops", 32'(n_pops - p0), 32'd20);
    chk("wrap_cnt", 32'(fifo_count), 32'd0);

    // reset while in CLEAR with three entries and overflow set
    fill(9, 8'h40);
    repeat (5) pop1();
    chk("pre_rst_cnt", 32'(fifo_count), 32'd3);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    rx_data = 8'hC3; parity_error = 1'b0; rx_flag = 1'b1;
    step();
    step();
    chk("mid_clr", 32'(rx_flag_clr), 32'd1);
    n_rst = 1'b0;
    #2;
    chk("arst_clr",  32'(rx_flag_clr), 32'd0);
    chk("arst_vld",  32'(rd_valid), 32'd0);
    chk("arst_cnt",  32'(fifo_count), 32'd0);
    chk("arst_ovf",  32'(overflow), 32'd0);
    chk("arst_data", 32'(rd_data), 32'd0);
    mq.delete();
    ovf_m = 1'b0;
    step();
    n_rst = 1'b1;
    send_byte(8'hC3, 1'b0, 3, 1'b0);
    chk("rearm_cnt",  32'(fifo_count), 32'd1);
    chk("rearm_data", 32'(rd_data), 32'hC3);
    pop1();

    // randomized mix
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          rd_ready = ($urandom_range(0, 3) == 0);
          send_byte(DW'($urandom), 1'($urandom), int'($urandom_range(1, 4)), 1'b0);
          rd_ready = 1'b0;
        end
        3: begin
          rd_ready = 1'b1;
          repeat ($urandom_range(1, 3)) step();
          rd_ready = 1'b0;
        end
        4: begin
          overflow_clr = 1'b1;
          step();
          overflow_clr = 1'b0;
        end
        default: begin
          rd_ready = 1'($urandom);
          step();
          rd_ready = 1'b0;
        end
      endcase
    end
    rd_ready = 1'b1;
    repeat (DEPTH + 2) step();
    rd_ready = 1'b0;
    chk("final_empty", 32'(rd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
